spike_aer_network: RTL and testbench

SPIKE_AER_NETWORK -- requirements
Module: spike_aer_network

---
 rtl/snn_pkg.sv | 30 +++
 rtl/spike_pri_enc.sv | 23 ++
 rtl/spike_aer_network.sv | 118 +++++++++++
 tb/tb_spike_aer_network.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared sizing, FSM state type and address-event word layout for the AER spike network.
package snn_pkg;

  localparam int unsigned T_DEF    = 4;
  localparam int unsigned N_DEF    = 16;
  localparam int unsigned TS_W_DEF = 16;

  // Address fields need at least one bit even when only one block exists.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int unsigned TA_DEF = clog2_min1(T_DEF);
  localparam int unsigned NA_DEF = $clog2(N_DEF);
  localparam int unsigned W_DEF  = 1 + TS_W_DEF + TA_DEF + NA_DEF;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StEos
  } aer_state_t;

  typedef struct packed {
    logic                eos;
    logic [TS_W_DEF-1:0] ts;
    logic [TA_DEF-1:0]   block;
    logic [NA_DEF-1:0]   neuron;
  } aer_word_t;

endpackage

// File: rtl/spike_pri_enc.sv
// Lowest-set-bit search over a flat spike vector; returns bit index and a found flag.
module spike_pri_enc #(
  parameter int unsigned Width = 8,
  localparam int unsigned IdxW = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] vec,
  output logic [IdxW-1:0]  idx,
  output logic             found
);

  // Walk downwards so the last hit written is the lowest set bit.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IdxW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_aer_network.sv
// Serialises per-time-step spike vectors into an address-event stream closed by an EOS word.
module spike_aer_network
  import snn_pkg::*;
#(
  parameter int unsigned T    = T_DEF,
  parameter int unsigned N    = N_DEF,
  parameter int unsigned TS_W = TS_W_DEF,
  localparam int unsigned TA  = clog2_min1(T),
  localparam int unsigned NA  = $clog2(N),
  localparam int unsigned W   = 1 + TS_W + TA + NA
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [T-1:0][N-1:0]   spike_in,
  input  logic                  time_step,
  input  logic                  force_spike_en,
  input  logic [TA-1:0]         force_spike_block_select,
  input  logic [NA-1:0]         force_spike_neuron_select,
  output logic [W-1:0]          axis_out_tdata,
  output logic                  axis_out_tvalid,
  input  logic                  axis_out_tready,
  output logic                  axis_out_tlast,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned TN = T * N;
  localparam int unsigned IW = clog2_min1(TN);

  aer_state_t       state_q;
  logic [TN-1:0]    scan_q, pend_q, force_oh;
  logic [TS_W-1:0]  ts_cnt_q, ts_cap_q;
  logic [W-1:0]     tdata_q;
  logic             tvalid_q, tlast_q, ovf_q;
  logic [IW-1:0]    hit_idx;
  logic             hit_found;
  logic [TA-1:0]    hit_blk;
  logic [NA-1:0]    hit_nrn;
  logic             can_load;

  spike_pri_enc #(
    .Width(TN)
  ) u_pri_enc (
    .vec  (scan_q),
    .idx  (hit_idx),
    .found(hit_found)
  );

  // Out-of-range block selects produce no pending bit at all.
  always_comb begin
    force_oh = '0;
    if (force_spike_en && (32'(force_spike_block_select) < T)) begin
      force_oh = TN'(1) << (32'(force_spike_block_select) * N + 32'(force_spike_neuron_select));
    end
  end

  assign hit_nrn  = hit_idx[NA-1:0];
  assign hit_blk  = TA'(32'(hit_idx) >> NA);
  assign can_load = !tvalid_q || axis_out_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      scan_q   <= '0;
      pend_q   <= '0;
      ts_cnt_q <= '0;
      ts_cap_q <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (time_step && busy) ovf_q <= 1'b1;
      pend_q <= pend_q | force_oh;
      case (state_q)
        StIdle: begin
          // A force request in the same cycle is merged into this step.
          if (time_step && !tvalid_q) begin
            scan_q   <= spike_in | pend_q | force_oh;
            ts_cap_q <= ts_cnt_q;
            pend_q   <= '0;
            state_q  <= StScan;
          end
        end
        StScan: begin
          if (can_load) begin
            tvalid_q <= 1'b1;
            if (hit_found) begin
              tdata_q <= {1'b0, ts_cap_q, hit_blk, hit_nrn};
              tlast_q <= 1'b0;
              scan_q  <= scan_q & ~(TN'(1) << hit_idx);
            end else begin
              tdata_q <= {1'b1, ts_cap_q, {TA{1'b0}}, {NA{1'b0}}};
              tlast_q <= 1'b1;
              state_q <= StEos;
            end
          end
        end
        StEos: begin
          if (axis_out_tready) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ts_cnt_q <= ts_cnt_q + TS_W'(1);
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign axis_out_tdata  = tdata_q;
  assign axis_out_tvalid = tvalid_q;
  assign axis_out_tlast  = tlast_q;
  assign busy            = (state_q != StIdle) || tvalid_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_spike_aer_network.sv
// Randomised and directed checks of spike_aer_network against a queue-based step model.
module tb_spike_aer_network;

  localparam int unsigned T    = 4;
  localparam int unsigned N    = 16;
  localparam int unsigned TS_W = 2;
  localparam int unsigned TA   = 2;
  localparam int unsigned NA   = 4;
  localparam int unsigned W    = 1 + TS_W + TA + NA;
  localparam int unsigned TN   = T * N;

  logic                clk = 1'b0;
  logic                reset;
  logic [T-1:0][N-1:0] spike_in;
  logic                time_step;
  logic                force_spike_en;
  logic [TA-1:0]       force_spike_block_select;
  logic [NA-1:0]       force_spike_neuron_select;
  logic [W-1:0]        tdata;
  logic                tvalid, tready, tlast, busy, overflow;

  spike_aer_network #(
    .T   (T),
    .N   (N),
    .TS_W(TS_W)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .spike_in                 (spike_in),
    .time_step                (time_step),
    .force_spike_en           (force_spike_en),
    .force_spike_block_select (force_spike_block_select),
    .force_spike_neuron_select(force_spike_neuron_select),
    .axis_out_tdata           (tdata),
    .axis_out_tvalid          (tvalid),
    .axis_out_tready          (tready),
    .axis_out_tlast           (tlast),
    .busy                     (busy),
    .overflow                 (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int got_q[$];
  logic [TN-1:0] pend_m = '0;
  int ts_m = 0;
  logic ovf_m = 1'b0;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1;
  int prev_w = 0;
  int tready_mode = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Word as {tlast, type, ts, block, neuron}; tlast mirrors the type bit.
  function automatic int mk(input int typ, input int ts, input int b, input int n);
    return (typ << 9) | (typ << 8) | (ts << 6) | (b << 4) | n;
  endfunction

  // Model: a whole step's words are queued when the step is accepted.
  always @(negedge clk) begin
    logic busy_m;
    logic [TN-1:0] f, v;
    int act;
    busy_m = exp_q.size() != 0;
    check("busy", int'(busy), int'(busy_m));
    check("overflow", int'(overflow), int'(ovf_m));
    if (!busy_m) check("tvalid_idle", int'(tvalid), 0);
    if (prev_v && !prev_r && !prev_rst) begin
      check("hold_valid", int'(tvalid), 1);
      check("hold_word", int'({tlast, tdata}), prev_w);
    end
    if (tvalid && tready && !reset) begin
      act = int'({tlast, tdata});
      got_q.push_back(act);
      if (exp_q.size() == 0) check("unexpected_word", act, -1);
      else check("word", act, exp_q.pop_front());
    end
    prev_v   = tvalid;
    prev_r   = tready;
    prev_rst = reset;
    prev_w   = int'({tlast, tdata});
    if (reset) begin
      exp_q.delete();
      pend_m = '0;
      ts_m   = 0;
      ovf_m  = 1'b0;
    end else begin
      f = '0;
      if (force_spike_en && int'(force_spike_block_select) < T)
        f = TN'(1) << (int'(force_spike_block_select) * N + int'(force_spike_neuron_select));
      if (time_step && busy_m) ovf_m = 1'b1;
      if (time_step && !busy_m) begin
        v = spike_in | pend_m | f;
        pend_m = '0;
        for (int i = 0; i < TN; i++)
          if (((v >> i) & TN'(1)) != '0) exp_q.push_back(mk(0, ts_m, i / N, i % N));
        exp_q.push_back(mk(1, ts_m, 0, 0));
        ts_m = (ts_m + 1) % (1 << TS_W);
      end else begin
        pend_m = pend_m | f;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (tready_mode)
      0: tready = 1'b1;
      1: tready = ~tready;
      default: tready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_pulse(input logic [T-1:0][N-1:0] sp);
    spike_in  = sp;
    time_step = 1'b1;
    tick();
    time_step = 1'b0;
    spike_in  = '0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || exp_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    check("drain_in_budget", int'(k < budget), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    got_q.delete();
  endtask

  task automatic check_log(input string name, input int e[$]);
    check({name, "_count"}, got_q.size(), e.size());
    for (int i = 0; i < e.size() && i < got_q.size(); i++) check(name, got_q[i], e[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [T-1:0][N-1:0] sp;
    int e[$];
    reset = 1'b1; spike_in = '0; time_step = 1'b0; force_spike_en = 1'b0;
    force_spike_block_select = '0; force_spike_neuron_select = '0; tready = 1'b1;
    repeat (3) tick();
    check("reset_tvalid", int'(tvalid), 0);
    check("reset_tdata", int'(tdata), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    got_q.delete();

    // Two events in block 2 then EOS.
    sp = '0; sp[2] = 16'h0005;
    step_pulse(sp);
    wait_idle(100);
    e = '{mk(0, 0, 2, 0), mk(0, 0, 2, 2), mk(1, 0, 0, 0)};
    check_log("basic", e);
    check("basic_literal", got_q.size() > 0 ? got_q[0] : -1, 'h020);

    // Three empty steps.
    do_reset();
    repeat (3) begin
      step_pulse('0);
      repeat (10) tick();
    end
    wait_idle(50);
    e = '{mk(1, 0, 0, 0), mk(1, 1, 0, 0), mk(1, 2, 0, 0)};
    check_log("empty", e);

    // Forced spike held until the next step, then gone.
    do_reset();
    repeat (5) tick();
    force_spike_en = 1'b1; force_spike_block_select = 2'd3; force_spike_neuron_select = 4'd15;
    tick();
    force_spike_en = 1'b0;
    repeat (14) tick();
    step_pulse('0);
    wait_idle(50);
    step_pulse('0);
    wait_idle(50);
    e = '{'h03F, 'h300, 'h340};
    check_log("force", e);

    // Full block under toggling tready.
    do_reset();
    tready_mode = 1;
    sp = '0; sp[0] = 16'hFFFF;
    step_pulse(sp);
    wait_idle(200);
    tready_mode = 0;
    e = '{};
    for (int i = 0; i < 16; i++) e.push_back(i);
    e.push_back('h300);
    check_log("backpressure", e);

    // Step during SCAN is dropped and flags overflow.
    do_reset();
    sp = '0; sp[1] = 16'h00F0;
    step_pulse(sp);
    tick();
    sp = '0; sp[3] = 16'h0001;
    step_pulse(sp);
    wait_idle(100);
    check("overflow_set", int'(overflow), 1);
    step_pulse('0);
    wait_idle(50);
    check("overflow_sticky", int'(overflow), 1);
    e = '{'h014, 'h015, 'h016, 'h017, 'h300, 'h340};
    check_log("overflow", e);

    // Reset mid-SCAN, then timestamp wrap.
    do_reset();
    sp = '0; sp[0] = 16'hFFFF;
    step_pulse(sp);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_tvalid", int'(tvalid), 0);
    check("abort_busy", int'(busy), 0);
    got_q.delete();
    repeat (5) begin
      step_pulse('0);
      wait_idle(50);
    end
    e = '{'h300, 'h340, 'h380, 'h3C0, 'h300};
    check_log("wrap", e);

    // Randomised traffic.
    do_reset();
    tready_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < T; b++) spike_in[b] = 16'($urandom & $urandom & $urandom);
      time_step                 = ($urandom_range(0, 5) == 0);
      force_spike_en            = ($urandom_range(0, 9) == 0);
      force_spike_block_select  = 2'($urandom_range(0, 3));
      force_spike_neuron_select = 4'($urandom_range(0, 15));
      reset                     = ($urandom_range(0, 299) == 0);
      tick();
    end
    spike_in = '0; time_step = 1'b0; force_spike_en = 1'b0; reset = 1'b0;
    tready_mode = 0;
    wait_idle(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
